// File: rtl/ntt_core_sequencer.sv
// Stage sequencer for one ntt_core: butterfly stages with write-back drain, then readout; done pulse at the end.
// Define NTT_SEQ_CYCLE_COUNT_EN to enable the busy-cycle counter on cycle_count (tied to 0 otherwise).
module ntt_core_sequencer #(
  parameter int LOG_DEPTH = 9,
  parameter int STAGES    = 10,
  parameter int PIPE_LAT  = 3,
  parameter int READ_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           log_m,
  output logic [LOG_DEPTH:0]   i,
  output logic [1:0]           mode,
  output logic [LOG_DEPTH-1:0] read_address,
  output logic                 upper_write_enable,
  output logic                 lower_write_enable,
  output logic [LOG_DEPTH-1:0] upper_write_address,
  output logic [LOG_DEPTH-1:0] lower_write_address,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [31:0]          cycle_count
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH-1:0] LAST_ADDR = LOG_DEPTH'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_READOUT, S_FLUSH, S_DONE} state_t;

  state_t               state;
  logic [LOG_DEPTH-1:0] addr;
  logic [15:0]          cnt;
  logic [LOG_DEPTH:0]   addr_ext;
  int                   shamt;

  logic                 wb_vld [PIPE_LAT];
  logic [LOG_DEPTH-1:0] wb_adr [PIPE_LAT];
  logic                 rd_vld [READ_LAT];
  logic                 rd_lst [READ_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      addr  <= '0;
      cnt   <= '0;
      log_m <= '0;
      mode  <= 2'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            addr  <= '0;
            log_m <= 4'd1;
            mode  <= 2'd1;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (addr == LAST_ADDR) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        // Hold off the next stage until the last write-back of this one has landed.
        S_DRAIN: begin
          if (cnt == 16'(PIPE_LAT - 1)) begin
            addr <= '0;
            if (log_m == 4'(STAGES)) begin
              state <= S_READOUT;
              mode  <= 2'd3;
            end else begin
              state <= S_RUN;
              log_m <= log_m + 4'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_READOUT: begin
          if (addr == LAST_ADDR) begin
            state <= S_FLUSH;
            cnt   <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_FLUSH: begin
          if (cnt == 16'(READ_LAT - 1)) begin
            state <= S_DONE;
            mode  <= 2'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          addr  <= '0;
          log_m <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign read_address = addr;
  assign addr_ext     = {1'b0, addr};

  always_comb begin
    i     = '0;
    shamt = LOG_DEPTH + 1 - int'(log_m);
    if (state == S_RUN || state == S_DRAIN)
      i = addr_ext >> shamt;
  end

  // Write-back and readout delay lines keep shifting in every state so nothing is stranded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        wb_vld[k] <= 1'b0;
        wb_adr[k] <= '0;
      end
      for (int k = 0; k < READ_LAT; k++) begin
        rd_vld[k] <= 1'b0;
        rd_lst[k] <= 1'b0;
      end
    end else begin
      wb_vld[0] <= (state == S_RUN);
      wb_adr[0] <= addr;
      for (int k = 1; k < PIPE_LAT; k++) begin
        wb_vld[k] <= wb_vld[k-1];
        wb_adr[k] <= wb_adr[k-1];
      end
      rd_vld[0] <= (state == S_READOUT);
      rd_lst[0] <= (state == S_READOUT) && (addr == LAST_ADDR);
      for (int k = 1; k < READ_LAT; k++) begin
        rd_vld[k] <= rd_vld[k-1];
        rd_lst[k] <= rd_lst[k-1];
      end
    end
  end

  assign upper_write_enable  = wb_vld[PIPE_LAT-1];
  assign lower_write_enable  = wb_vld[PIPE_LAT-1];
  assign upper_write_address = wb_adr[PIPE_LAT-1];
  assign lower_write_address = wb_adr[PIPE_LAT-1];
  assign out_valid           = rd_vld[READ_LAT-1];
  assign out_last            = rd_lst[READ_LAT-1];

`ifdef NTT_SEQ_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_count <= '0;
    else if (state == S_IDLE && start)
      cycle_count <= '0;
    else if (busy)
      cycle_count <= cycle_count + 32'd1;
  end
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_ntt_core_sequencer.sv
// Bench for ntt_core_sequencer at LOG_DEPTH=2, STAGES=3, PIPE_LAT=2, READ_LAT=1 with a per-cycle expected-output queue.
module tb_ntt_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, uwe, lwe, out_valid, out_last;
  logic [3:0]  log_m;
  logic [2:0]  i;
  logic [1:0]  mode, read_address, uwa, lwa;
  logic [31:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] mode;
    logic [3:0] log_m;
    logic [2:0] i;
    logic [1:0] ra;
    logic       uwe;
    logic       lwe;
    logic [1:0] uwa;
    logic [1:0] lwa;
    logic       ov;
    logic       ol;
  } snap_t;

  typedef struct packed {
    snap_t v;
    snap_t m;
  } exp_t;

  exp_t sb[$];

  localparam int RUN_LEN = 24;

`ifdef NTT_SEQ_CYCLE_COUNT_EN
  localparam logic [31:0] CC_AFTER = 32'd23;
`else
  localparam logic [31:0] CC_AFTER = 32'd0;
`endif

  ntt_core_sequencer #(.LOG_DEPTH(2), .STAGES(3), .PIPE_LAT(2), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .log_m(log_m), .i(i), .mode(mode), .read_address(read_address),
    .upper_write_enable(uwe), .lower_write_enable(lwe),
    .upper_write_address(uwa), .lower_write_address(lwa),
    .out_valid(out_valid), .out_last(out_last), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic snap_t sample();
    snap_t s;
    s.busy = busy; s.done = done; s.mode = mode; s.log_m = log_m; s.i = i;
    s.ra = read_address; s.uwe = uwe; s.lwe = lwe; s.uwa = uwa; s.lwa = lwa;
    s.ov = out_valid; s.ol = out_last;
    return s;
  endfunction

  // Independent model of one full transform, one entry per cycle from start acceptance through done.
  task automatic build_expected();
    snap_t v[RUN_LEN];
    snap_t m[RUN_LEN];
    exp_t  e;
    int    t = 0;
    for (int k = 0; k < RUN_LEN; k++) begin
      v[k] = '0;
      m[k] = '0;
      m[k].busy = 1'b1; m[k].done = 1'b1; m[k].mode = 2'b11;
      m[k].uwe = 1'b1; m[k].lwe = 1'b1; m[k].ov = 1'b1; m[k].ol = 1'b1;
    end
    for (int s = 1; s <= 3; s++) begin
      for (int a = 0; a < 4; a++) begin
        v[t].busy = 1'b1; v[t].mode = 2'd1;
        v[t].log_m = 4'(s); m[t].log_m = 4'hf;
        v[t].ra = 2'(a); m[t].ra = 2'b11;
        v[t].i = 3'(a >> (3 - s)); m[t].i = 3'b111;
        v[t+2].uwe = 1'b1; v[t+2].lwe = 1'b1;
        v[t+2].uwa = 2'(a); v[t+2].lwa = 2'(a);
        m[t+2].uwa = 2'b11; m[t+2].lwa = 2'b11;
        t++;
      end
      for (int d = 0; d < 2; d++) begin
        v[t].busy = 1'b1; v[t].mode = 2'd1;
        v[t].log_m = 4'(s); m[t].log_m = 4'hf;
        v[t].ra = 2'd3; m[t].ra = 2'b11;
        t++;
      end
    end
    for (int a = 0; a < 4; a++) begin
      v[t].busy = 1'b1; v[t].mode = 2'd3;
      v[t].ra = 2'(a); m[t].ra = 2'b11;
      m[t].i = 3'b111;
      v[t+1].ov = 1'b1; v[t+1].ol = (a == 3);
      t++;
    end
    v[t].busy = 1'b1; v[t].mode = 2'd3;
    t++;
    v[t].done = 1'b1;
    for (int k = 0; k < RUN_LEN; k++) begin
      e.v = v[k];
      e.m = m[k];
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    snap_t o;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    o = sample();
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    n_cmp++;
    if (cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_cycle_count: got %0d want 0", cycle_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // glitch_at >= 0 pulses start during that cycle of the run; it must be ignored.
  task automatic test_full_run(input int glitch_at, input string tag);
    exp_t  e;
    snap_t o;
    int    busy_n = 0;
    build_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < RUN_LEN; k++) begin
      start = (k == glitch_at);
      e = sb.pop_front();
      o = sample();
      n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %h want %h (mask %h)", tag, k, o, e.v, e.m);
      end
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (busy_n != 23) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want 23", tag, busy_n);
    end
    n_cmp++;
    if (busy !== 1'b0 || mode !== 2'd0 || done !== 1'b0 || uwe !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after: busy %b mode %0d done %b we %b ov %b, want all 0", tag, busy, mode, done, uwe, out_valid);
    end
    n_cmp++;
    if (cycle_count !== CC_AFTER) begin
      n_err++;
      $display("FAIL %s cycle_count: got %0d want %0d", tag, cycle_count, CC_AFTER);
    end
  endtask

  task automatic test_start_while_busy();
    test_full_run(8, "start_while_busy");
  endtask

  task automatic test_reset_mid_run();
    snap_t o;
    int    strobes = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    o = sample();
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset_mid_run_outputs: got %h want 0", o);
    end
    n_cmp++;
    if (cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_run_cycle_count: got %0d want 0", cycle_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (uwe !== 1'b0 || lwe !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) strobes++;
      @(negedge clk);
    end
    n_cmp++;
    if (strobes != 0) begin
      n_err++;
      $display("FAIL reset_mid_run_quiet: got %0d active cycles want 0", strobes);
    end
    test_full_run(-1, "run_after_reset");
  endtask

  initial begin
    test_reset();
    test_full_run(-1, "full_run");
    test_start_while_busy();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
